// File: rtl/seq_divider_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// master drives request/flush; slave returns busy/valid/result.
interface seq_divider_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Ports: clk, rst_n (async active-low), bus (slave: start/op/a/b/flush in, busy/valid/result out).
module seq_divider #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_rem;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN:0]   w_sh;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_fin_q;
    logic [XLEN-1:0] w_fin_r;
    logic [XLEN-1:0] w_final;

    // op_i[0]=0 selects the signed variants, op_i[1]=1 selects remainder
    assign w_signed  = ~bus.op_i[0];
    assign w_a_neg   = w_signed & bus.a_i[XLEN-1];
    assign w_b_neg   = w_signed & bus.b_i[XLEN-1];
    assign w_a_abs   = w_a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
    assign w_b_abs   = w_b_neg ? (~bus.b_i + 1'b1) : bus.b_i;
    assign w_b_zero  = (bus.b_i == '0);
    assign w_ovf     = w_signed && (bus.a_i == MIN_INT) && (bus.b_i == '1);
    assign w_special = w_b_zero | w_ovf;

    // Partial remainder shifted left with the next dividend bit, then trial subtract
    assign w_sh    = {r_rem, r_quo[XLEN-1]};
    assign w_trial = w_sh - {1'b0, r_div};

    // Two's complement negation keeps zero at zero
    assign w_fin_q = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_fin_r = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    assign w_final = r_is_rem ? w_fin_r : w_fin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        w_state_nxt = w_special ? S_DONE : S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Result is presented directly from the datapath while in DONE and
    // captured into r_result so it holds until the next completion.
    always_comb begin
        bus.busy_o   = (r_state != S_IDLE);
        bus.valid_o  = (r_state == S_DONE);
        bus.result_o = (r_state == S_DONE) ? w_final : r_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (!bus.flush_i) begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_is_rem <= bus.op_i[1];
                        r_cnt    <= CW'(XLEN-1);
                        if (w_b_zero) begin
                            // Special results are final; no sign fixup
                            r_quo   <= '1;
                            r_rem   <= bus.a_i;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_ovf) begin
                            r_quo   <= MIN_INT;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_quo   <= w_a_abs;
                            r_rem   <= '0;
                            r_div   <= w_b_abs;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (!w_trial[XLEN]) begin
                        r_rem <= w_trial[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_sh[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 1'b1;
                end
                S_DONE:  r_result <= w_final;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed check of seq_divider against an arithmetic model.
// Drives on negedge, samples on negedge; all checks go through chk().
module tb_seq_divider;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    seq_divider_if #(.XLEN(XLEN)) bus ();

    seq_divider #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Issue one op and wait for valid_o; lat counts cycles after the accept edge
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = 1;
        while (!bus.valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " lat"}, lat, ref_lat(op, a, b));
        chk({tag, " res"}, bus.result_o, exp);
        @(negedge clk);
        chk({tag, " idle"}, {31'd0, bus.busy_o}, 32'd0);
        chk({tag, " hold"}, bus.result_o, exp);
    endtask

    logic [1:0]  t_op [8];
    logic [31:0] t_a  [8];
    logic [31:0] t_b  [8];
    logic [31:0] t_e  [8];

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          nv;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 2'd0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst result", bus.result_o, 32'd0);
        rst_n = 1'b1;

        t_op[0] = 2'd0; t_a[0] = 32'd100;        t_b[0] = 32'd7;          t_e[0] = 32'd14;
        t_op[1] = 2'd2; t_a[1] = 32'd100;        t_b[1] = 32'd7;          t_e[1] = 32'd2;
        t_op[2] = 2'd0; t_a[2] = 32'hFFFF_FFF9;  t_b[2] = 32'd2;          t_e[2] = 32'hFFFF_FFFD;
        t_op[3] = 2'd2; t_a[3] = 32'hFFFF_FFF9;  t_b[3] = 32'd2;          t_e[3] = 32'hFFFF_FFFF;
        t_op[4] = 2'd3; t_a[4] = 32'hFFFF_FFF9;  t_b[4] = 32'd2;          t_e[4] = 32'd1;
        t_op[5] = 2'd1; t_a[5] = 32'hFFFF_FFFF;  t_b[5] = 32'd1;          t_e[5] = 32'hFFFF_FFFF;
        t_op[6] = 2'd0; t_a[6] = 32'h1234;       t_b[6] = 32'd0;          t_e[6] = 32'hFFFF_FFFF;
        t_op[7] = 2'd0; t_a[7] = 32'h8000_0000;  t_b[7] = 32'hFFFF_FFFF;  t_e[7] = 32'h8000_0000;
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("dir%0d", i), t_op[i], t_a[i], t_b[i], t_e[i]);
        end
        run_op("divu lt", 2'd1, 32'd5, 32'd9, 32'd0);
        run_op("remu lt", 2'd3, 32'd5, 32'd9, 32'd5);
        run_op("rem b0", 2'd2, 32'h1234, 32'd0, 32'h1234);
        run_op("rem ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = $urandom_range(1, 15);
                3: begin b = $urandom; a = $urandom_range(0, 1000); end
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b));
        end

        // Start pulse while busy is ignored
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'd1;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = 1;
        while (!bus.valid_o && lat < 100) begin
            if (lat == 4) begin
                bus.start_i = 1'b1;
                bus.op_i    = 2'd0;
                bus.a_i     = 32'd77;
                bus.b_i     = 32'd0;
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start_i = 1'b0;
        chk("ign lat", lat, XLEN + 1);
        chk("ign res", bus.result_o, 32'd33);
        @(negedge clk);
        chk("ign idle", {31'd0, bus.busy_o}, 32'd0);

        // Flush at T+10 aborts, result_o kept
        bus.start_i = 1'b1;
        bus.op_i    = 2'd1;
        bus.a_i     = 32'd1000;
        bus.b_i     = 32'd7;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (8) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("fl busy", {31'd0, bus.busy_o}, 32'd0);
        chk("fl valid", {31'd0, bus.valid_o}, 32'd0);
        chk("fl keep", bus.result_o, 32'd33);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_o) nv++;
        end
        chk("fl novalid", nv, 0);
        run_op("post fl", 2'd1, 32'd1000, 32'd7, 32'd142);

        // Reset mid-op clears outputs at once
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 2'd0;
        bus.a_i     = 32'd5000;
        bus.b_i     = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr busy", {31'd0, bus.busy_o}, 32'd0);
        chk("mr valid", {31'd0, bus.valid_o}, 32'd0);
        chk("mr result", bus.result_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_o) nv++;
        end
        chk("mr novalid", nv, 0);
        run_op("post rst", 2'd2, 32'd5000, 32'd3, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
